crack_sched: RTL

- Top-level sequencer for NUM_ENG parallel ARC4 crack engines.
- Launches all engines on an interleaved keyspace: engine i tries keys i, i+NUM_ENG, and so on. Each engine receives its base key; the stride is the parameter NUM_ENG.
- Collects results, aborts losing engines, and reports the first key found.
- Also arbitrates the single-port ct_mem read port among the engines using round-robin.

---
 rtl/crack_sched_if.sv | 37 +++
 rtl/crack_sched.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/crack_sched_if.sv
// Controller-side bundle for crack_sched: host start/result handshake,
// per-engine launch/abort/result lines and the shared ct_mem read port.
interface crack_sched_if #(
   parameter int NUM_ENG = 2
);
   logic                    en;
   logic                    rdy;
   logic [23:0]             key;
   logic                    key_valid;
   logic [NUM_ENG-1:0]      eng_en;
   logic [NUM_ENG-1:0]      eng_abort;
   logic [NUM_ENG*24-1:0]   eng_base;
   logic [NUM_ENG-1:0]      eng_rdy;
   logic [NUM_ENG-1:0]      eng_key_valid;
   logic [NUM_ENG*24-1:0]   eng_key;
   logic [NUM_ENG-1:0]      eng_ct_req;
   logic [NUM_ENG*8-1:0]    eng_ct_addr;
   logic [NUM_ENG-1:0]      eng_ct_gnt;
   logic [NUM_ENG-1:0]      eng_ct_rvalid;
   logic [7:0]              eng_ct_rddata;
   logic [7:0]              ct_addr;
   logic [7:0]              ct_rddata;

   modport master (
      input  en, eng_rdy, eng_key_valid, eng_key,
      input  eng_ct_req, eng_ct_addr, ct_rddata,
      output rdy, key, key_valid, eng_en, eng_abort, eng_base,
      output eng_ct_gnt, eng_ct_rvalid, eng_ct_rddata, ct_addr
   );

   modport slave (
      output en, eng_rdy, eng_key_valid, eng_key,
      output eng_ct_req, eng_ct_addr, ct_rddata,
      input  rdy, key, key_valid, eng_en, eng_abort, eng_base,
      input  eng_ct_gnt, eng_ct_rvalid, eng_ct_rddata, ct_addr
   );
endinterface

// File: rtl/crack_sched.sv
// Sequencer for NUM_ENG interleaved ARC4 crack engines plus a
// round-robin arbiter for the shared ct_mem read port.
module crack_sched #(
   parameter int NUM_ENG = 2
) (
   input  logic             clk,
   input  logic             rst,
   crack_sched_if.master    bus
);
   localparam int PW = (NUM_ENG > 1) ? $clog2(NUM_ENG) : 1;

   localparam logic [2:0] IDLE   = 3'd0;
   localparam logic [2:0] LAUNCH = 3'd1;
   localparam logic [2:0] GUARD  = 3'd2;
   localparam logic [2:0] RUN    = 3'd3;
   localparam logic [2:0] DRAIN  = 3'd4;

   logic [2:0]          state_q, state_d;
   logic [23:0]         key_q, key_d;
   logic                key_valid_q, key_valid_d;
   logic [NUM_ENG-1:0]  eng_en_q, eng_en_d;
   logic [NUM_ENG-1:0]  eng_abort_q, eng_abort_d;
   logic [NUM_ENG-1:0]  busy_q, busy_d;
   logic [PW-1:0]       rr_ptr_q, rr_ptr_d;
   logic [NUM_ENG-1:0]  rvalid_q, rvalid_d;

   logic [NUM_ENG-1:0]  fin;
   logic [NUM_ENG-1:0]  hit;
   logic [23:0]         hit_key;
   logic [NUM_ENG-1:0]  mask;
   logic [NUM_ENG-1:0]  masked;
   logic [NUM_ENG-1:0]  pick;
   logic [NUM_ENG-1:0]  gnt;
   logic [PW-1:0]       gidx;
   logic [7:0]          addr;

   for (genvar i = 0; i < NUM_ENG; i++) begin : g_base
      assign bus.eng_base[i*24 +: 24] = 24'(i);
   end

   assign fin = busy_q & bus.eng_rdy;
   assign hit = fin & bus.eng_key_valid;

   // Descending scan leaves the lowest-index hit as the winner.
   always_comb begin
      hit_key = '0;
      for (int j = NUM_ENG - 1; j >= 0; j--) begin
         if (hit[j]) hit_key = bus.eng_key[j*24 +: 24];
      end
   end

   always_comb begin
      state_d     = state_q;
      key_d       = key_q;
      key_valid_d = key_valid_q;
      eng_en_d    = '0;
      eng_abort_d = '0;
      busy_d      = busy_q;
      case (state_q)
         IDLE: begin
            if (bus.en) begin
               key_d       = '0;
               key_valid_d = 1'b0;
               state_d     = LAUNCH;
            end
         end
         LAUNCH: begin
            if (&bus.eng_rdy) begin
               eng_en_d = '1;
               busy_d   = '1;
               state_d  = GUARD;
            end
         end
         GUARD: state_d = RUN;
         RUN: begin
            busy_d = busy_q & ~fin;
            if (|hit) begin
               key_d       = hit_key;
               key_valid_d = 1'b1;
               eng_abort_d = busy_q & ~fin;
               state_d     = DRAIN;
            end else if (busy_d == '0) begin
               key_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         DRAIN: begin
            busy_d = busy_q & ~bus.eng_rdy;
            if (busy_d == '0) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Requests at or above rr_ptr win first; otherwise wrap to the lowest.
   always_comb begin
      for (int j = 0; j < NUM_ENG; j++) begin
         mask[j] = (j >= int'(rr_ptr_q));
      end
      masked = bus.eng_ct_req & mask;
      pick   = (|masked) ? masked : bus.eng_ct_req;
      gnt    = pick & (~pick + NUM_ENG'(1));
      gidx   = '0;
      addr   = '0;
      for (int j = 0; j < NUM_ENG; j++) begin
         if (gnt[j]) begin
            gidx = PW'(j);
            addr = bus.eng_ct_addr[j*8 +: 8];
         end
      end
      rr_ptr_d = rr_ptr_q;
      if (|gnt) begin
         rr_ptr_d = (int'(gidx) == NUM_ENG - 1) ? '0 : gidx + 1'b1;
      end
      rvalid_d = gnt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         key_q       <= '0;
         key_valid_q <= 1'b0;
         eng_en_q    <= '0;
         eng_abort_q <= '0;
         busy_q      <= '0;
         rr_ptr_q    <= '0;
         rvalid_q    <= '0;
      end else begin
         state_q     <= state_d;
         key_q       <= key_d;
         key_valid_q <= key_valid_d;
         eng_en_q    <= eng_en_d;
         eng_abort_q <= eng_abort_d;
         busy_q      <= busy_d;
         rr_ptr_q    <= rr_ptr_d;
         rvalid_q    <= rvalid_d;
      end
   end

   assign bus.rdy           = (state_q == IDLE);
   assign bus.key           = key_q;
   assign bus.key_valid     = key_valid_q;
   assign bus.eng_en        = eng_en_q;
   assign bus.eng_abort     = eng_abort_q;
   assign bus.eng_ct_gnt    = gnt;
   assign bus.eng_ct_rvalid = rvalid_q;
   assign bus.eng_ct_rddata = bus.ct_rddata;
   assign bus.ct_addr       = addr;
endmodule
